// File: rtl/wb_stage.sv
// Writeback stage: registers memory-stage results, waits for load data, extends it,
// and drives the register-file write port. Also counts retirements and flags bad loads.
module wb_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_opr_res,
  input  logic [DATA_WIDTH-1:0] in_pc4,
  input  logic [4:0]            in_rd,
  input  logic                  in_rf_en,
  input  logic [1:0]            in_wb_sel,
  input  logic                  in_is_load,
  input  logic [2:0]            in_lsuop,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  load_misalign,
  output logic                  load_timeout,
  output logic [CNT_W-1:0]      retire_count
);

  localparam int TW = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic [0:0] {IDLE, LOAD_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   opr_res_q, opr_res_d, pc4_q, pc4_d;
  logic [4:0]              rd_q, rd_d;
  logic                    rf_en_q, rf_en_d;
  logic [1:0]              wb_sel_q, wb_sel_d;
  logic [2:0]              lsuop_q, lsuop_d;
  logic                    rf_we_q, rf_we_d;
  logic [4:0]              rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
  logic                    misalign_q, misalign_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_W-1:0]        retire_q, retire_d;
  logic [TW-1:0]           cnt_inc;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] op);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] a, input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      default:        return a != 2'b00;
    endcase
  endfunction

  assign in_ready = (state_q == IDLE);
  assign cnt_inc  = cnt_q + 1'b1;

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opr_res_d  = opr_res_q;
    pc4_d      = pc4_q;
    rd_d       = rd_q;
    rf_en_d    = rf_en_q;
    wb_sel_d   = wb_sel_q;
    lsuop_d    = lsuop_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    retire_d   = retire_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opr_res_d = in_opr_res;
          pc4_d     = in_pc4;
          rd_d      = in_rd;
          rf_en_d   = in_rf_en;
          wb_sel_d  = in_wb_sel;
          lsuop_d   = in_lsuop;
          if (!in_is_load) begin
            rf_we_d    = in_rf_en && (in_rd != 5'd0);
            rf_waddr_d = in_rd;
            rf_wdata_d = (in_wb_sel == 2'b10) ? in_pc4 : in_opr_res;
            retire_d   = retire_q + 1'b1;
          end else if (misaligned(in_opr_res[1:0], in_lsuop)) begin
            misalign_d = 1'b1;
            retire_d   = retire_q + 1'b1;
          end else begin
            state_d = LOAD_WAIT;
            cnt_d   = '0;
          end
        end
      end
      LOAD_WAIT: begin
        if (dmem_rvalid) begin
          rf_we_d    = rf_en_q && (rd_q != 5'd0);
          rf_waddr_d = rd_q;
          case (wb_sel_q)
            2'b01:   rf_wdata_d = extract(dmem_rdata, opr_res_q[1:0], lsuop_q);
            2'b10:   rf_wdata_d = pc4_q;
            default: rf_wdata_d = opr_res_q;
          endcase
          retire_d = retire_q + 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TW'(LOAD_TIMEOUT)) begin
            timeout_d = 1'b1;
            retire_d  = retire_q + 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block with non-blocking updates.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opr_res_q  <= '0;
      pc4_q      <= '0;
      rd_q       <= '0;
      rf_en_q    <= 1'b0;
      wb_sel_q   <= '0;
      lsuop_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opr_res_q  <= opr_res_d;
      pc4_q      <= pc4_d;
      rd_q       <= rd_d;
      rf_en_q    <= rf_en_d;
      wb_sel_q   <= wb_sel_d;
      lsuop_q    <= lsuop_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
      retire_q   <= retire_d;
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign load_misalign = misalign_q;
  assign load_timeout  = timeout_q;
  assign retire_count  = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, reset-during-load sequence,
// and random transactions scored against an arithmetic reference model.
module tb_wb_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_opr_res, in_pc4;
  logic [4:0]  in_rd;
  logic        in_rf_en;
  logic [1:0]  in_wb_sel;
  logic        in_is_load;
  logic [2:0]  in_lsuop;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_misalign, load_timeout;
  logic [31:0] retire_count;

  wb_stage #(.DATA_WIDTH(32), .LOAD_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opr_res(in_opr_res), .in_pc4(in_pc4), .in_rd(in_rd), .in_rf_en(in_rf_en),
    .in_wb_sel(in_wb_sel), .in_is_load(in_is_load), .in_lsuop(in_lsuop),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .load_misalign(load_misalign),
    .load_timeout(load_timeout), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] opr_res;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        rf_en;
    logic [1:0]  wb_sel;
    logic        is_load;
    logic [2:0]  lsuop;
    int          delay;
    logic [31:0] rdata;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_mis;
    logic        exp_to;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input vec_t v);
    check("rf_we", {31'b0, rf_we}, {31'b0, v.exp_we});
    check("rf_waddr", {27'b0, rf_waddr}, {27'b0, v.exp_waddr});
    check("rf_wdata", rf_wdata, v.exp_wdata);
    check("load_misalign", {31'b0, load_misalign}, {31'b0, v.exp_mis});
    check("load_timeout", {31'b0, load_timeout}, {31'b0, v.exp_to});
    check("retire_count", retire_count, exp_cnt);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rf_we"}, {31'b0, rf_we}, 32'd0);
    check({tag, "_pulses"}, {30'b0, load_misalign, load_timeout}, 32'd0);
    check({tag, "_retire"}, retire_count, exp_cnt);
  endtask

  task automatic scramble();
    in_opr_res = $urandom;
    in_pc4     = $urandom;
    in_rd      = 5'($urandom);
    in_rf_en   = 1'($urandom);
    in_wb_sel  = 2'($urandom);
    in_is_load = 1'($urandom);
    in_lsuop   = 3'($urandom);
  endtask

  task automatic do_txn(input vec_t v);
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_opr_res = v.opr_res; in_pc4 = v.pc4; in_rd = v.rd; in_rf_en = v.rf_en;
    in_wb_sel = v.wb_sel; in_is_load = v.is_load; in_lsuop = v.lsuop;
    in_valid = 1'b1; dmem_rvalid = 1'b0;
    step();
    in_valid = 1'b0;
    scramble();
    if (!v.is_load || v.exp_mis) begin
      exp_cnt++;
      check_out(v);
    end else begin
      for (int k = 0; k < TO; k++) begin
        check("in_ready_wait", {31'b0, in_ready}, 32'd0);
        in_valid = 1'($urandom);
        if (k == v.delay) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = v.rdata;
          step();
          dmem_rvalid = 1'b0;
          in_valid    = 1'b0;
          dmem_rdata  = $urandom;
          exp_cnt++;
          check_out(v);
          break;
        end
        step();
        in_valid = 1'b0;
        if (k == TO - 1) begin
          exp_cnt++;
          check_out(v);
        end else begin
          check_quiet("wait");
        end
      end
    end
  endtask

  // One idle cycle with stray rvalid: outputs must return to zero and the count must hold.
  task automatic idle_cycle();
    dmem_rvalid = 1'b1;
    dmem_rdata  = $urandom;
    step();
    dmem_rvalid = 1'b0;
    check_quiet("idle");
    check("idle_waddr_wdata", rf_wdata | {27'b0, rf_waddr}, 32'd0);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  // Reference model: access size and lane selection by plain arithmetic on the address.
  function automatic int access_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd4) return 1;
    if (op == 3'd1 || op == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] op);
    longint v;
    longint unsigned off;
    off = longint'(addr % 4);
    case (access_size(op))
      1: begin
        v = longint'((rdata >> (8 * off)) % 256);
        if (op == 3'd0 && v >= 128) v = v - 256;
      end
      2: begin
        v = longint'((rdata >> (16 * (off / 2))) % 65536);
        if (op == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rdata);
    endcase
    return 32'(v);
  endfunction

  function automatic vec_t random_vec();
    vec_t v;
    logic [2:0] ops[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] data;
    int sz;
    v.is_load = 1'($urandom);
    v.lsuop   = ($urandom_range(0, 5) < 5) ? ops[$urandom_range(0, 4)] : 3'($urandom);
    v.opr_res = $urandom;
    sz = access_size(v.lsuop);
    if ($urandom_range(0, 1) == 1) v.opr_res = v.opr_res - (v.opr_res % sz);
    v.pc4     = $urandom;
    v.rd      = 5'($urandom);
    v.rf_en   = ($urandom_range(0, 3) != 0);
    v.wb_sel  = (v.is_load && $urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom);
    v.delay   = $urandom_range(0, 19);
    v.rdata   = $urandom;
    v.exp_mis = v.is_load && (v.opr_res % sz != 0);
    v.exp_to  = v.is_load && !v.exp_mis && v.delay >= TO;
    if (v.wb_sel == 2'b10)                data = v.pc4;
    else if (v.wb_sel == 2'b01 && v.is_load) data = model_load(v.rdata, v.opr_res, v.lsuop);
    else                                  data = v.opr_res;
    v.exp_we    = !v.exp_mis && !v.exp_to && v.rf_en && v.rd != 0;
    v.exp_waddr = (v.exp_mis || v.exp_to) ? 5'd0 : v.rd;
    v.exp_wdata = (v.exp_mis || v.exp_to) ? 32'd0 : data;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h1234, 32'h4, 5'd5, 1'b1, 2'b00, 1'b0, 3'd0, 0, 32'h0, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0};
    tbl[1]  = '{32'h103, 32'h8, 5'd7, 1'b1, 2'b01, 1'b1, 3'd0, 2, 32'h80FF_0000, 1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b0};
    tbl[2]  = '{32'h102, 32'h0, 5'd8, 1'b1, 2'b01, 1'b1, 3'd5, 0, 32'hBEEF_0000, 1'b1, 5'd8, 32'h0000_BEEF, 1'b0, 1'b0};
    tbl[3]  = '{32'h101, 32'h0, 5'd9, 1'b1, 2'b01, 1'b1, 3'd2, 0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0};
    tbl[4]  = '{32'h200, 32'h0, 5'd10, 1'b1, 2'b01, 1'b1, 3'd2, 20, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1};
    tbl[5]  = '{32'h55, 32'h0, 5'd0, 1'b1, 2'b00, 1'b0, 3'd0, 0, 32'h0, 1'b0, 5'd0, 32'h55, 1'b0, 1'b0};
    tbl[6]  = '{32'h999, 32'h44, 5'd1, 1'b1, 2'b10, 1'b0, 3'd0, 0, 32'h0, 1'b1, 5'd1, 32'h44, 1'b0, 1'b0};
    tbl[7]  = '{32'h102, 32'h0, 5'd11, 1'b1, 2'b01, 1'b1, 3'd1, 1, 32'h8001_0000, 1'b1, 5'd11, 32'hFFFF_8001, 1'b0, 1'b0};
    tbl[8]  = '{32'h101, 32'h0, 5'd12, 1'b1, 2'b01, 1'b1, 3'd4, 3, 32'h0000_AB00, 1'b1, 5'd12, 32'h0000_00AB, 1'b0, 1'b0};
    tbl[9]  = '{32'h103, 32'h0, 5'd13, 1'b1, 2'b01, 1'b1, 3'd1, 0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0};
    tbl[10] = '{32'h100, 32'h0, 5'd14, 1'b1, 2'b01, 1'b1, 3'd0, 15, 32'h1234_567F, 1'b1, 5'd14, 32'h0000_007F, 1'b0, 1'b0};
    tbl[11] = '{32'h99, 32'h8, 5'd15, 1'b1, 2'b01, 1'b0, 3'd0, 0, 32'h0, 1'b1, 5'd15, 32'h99, 1'b0, 1'b0};
    tbl[12] = '{32'hAA, 32'h8, 5'd16, 1'b1, 2'b11, 1'b0, 3'd0, 0, 32'h0, 1'b1, 5'd16, 32'hAA, 1'b0, 1'b0};
    tbl[13] = '{32'hBB, 32'h0, 5'd3, 1'b0, 2'b00, 1'b0, 3'd0, 0, 32'h0, 1'b0, 5'd3, 32'hBB, 1'b0, 1'b0};
    tbl[14] = '{32'h4, 32'h0, 5'd17, 1'b1, 2'b01, 1'b1, 3'd3, 4, 32'hDEAD_BEEF, 1'b1, 5'd17, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[15] = '{32'h2, 32'h0, 5'd18, 1'b1, 2'b01, 1'b1, 3'd3, 0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0};
    tbl[16] = '{32'h101, 32'h0, 5'd19, 1'b1, 2'b01, 1'b1, 3'd0, 0, 32'h0000_8000, 1'b1, 5'd19, 32'hFFFF_FF80, 1'b0, 1'b0};
    tbl[17] = '{32'h300, 32'h0, 5'd20, 1'b1, 2'b01, 1'b1, 3'd2, 16, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1};

    arst_n = 1'b0; in_valid = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    scramble();
    repeat (3) step();
    check("reset_outputs", {rf_we, load_misalign, load_timeout, rf_waddr} | rf_wdata, 32'd0);
    check("reset_retire", retire_count, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    arst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      do_txn(tbl[i]);
      idle_cycle();
    end

    // Back-to-back non-loads retire one per cycle.
    do_txn(tbl[0]);
    do_txn(tbl[6]);
    do_txn(tbl[12]);
    idle_cycle();

    // Reset while waiting for load data; the late rvalid must be ignored.
    in_opr_res = 32'h10; in_rd = 5'd21; in_rf_en = 1'b1; in_wb_sel = 2'b01;
    in_is_load = 1'b1; in_lsuop = 3'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("midload_in_ready", {31'b0, in_ready}, 32'd0);
    arst_n = 1'b0;
    step();
    arst_n = 1'b1;
    exp_cnt = 0;
    check("midload_reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("midload_reset_retire", retire_count, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_rvalid = 1'b0;
    check_quiet("late_rvalid");

    for (int n = 0; n < 300; n++) begin
      do_txn(random_vec());
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
